// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: drives a combinational ROM and queues {pc, inst} in a small prefetch FIFO.
// Optional address bounds checking with fault state is enabled by defining INST_FETCH_BOUNDS_CHECK_EN.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [CW-1:0] count_reg, count_next;
    logic          fault_reg, fault_next;
    logic          pop, push, flush;
    logic          pc_oob, redir_bad;
    logic [CW-1:0] wr_idx;

    // Each entry is {pc, inst}; entry 0 is the registered FIFO head.
    logic [FIFO_DEPTH-1:0][63:0] ent_reg, ent_next, shift_src;

`ifdef INST_FETCH_BOUNDS_CHECK_EN
    assign pc_oob    = (pc_reg[31:7] != 25'd0);
    assign redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc[31:7] != 25'd0);
`else
    assign pc_oob    = 1'b0;
    assign redir_bad = 1'b0;
`endif

    assign rom_addr  = pc_reg;
    assign out_valid = (count_reg != '0);
    assign out_pc    = ent_reg[0][63:32];
    assign out_inst  = ent_reg[0][31:0];
    assign fault     = fault_reg;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        fault_next = fault_reg;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state_reg)
            IDLE: state_next = RUN;
            RUN: begin
                if (halt) begin
                    state_next = HALT;
                end else if ((count_reg < DEPTH_C) || pop) begin
                    if (pc_oob) begin
                        state_next = FAULT;
                        fault_next = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pc_next = pc_reg + 32'd4;
                    end
                end
            end
            HALT: begin
                if (!halt) state_next = RUN;
            end
            FAULT: state_next = FAULT;
        endcase

        // A redirect overrides any fetch decision made above for this cycle.
        if (redirect && (state_reg != FAULT)) begin
            flush = 1'b1;
            push  = 1'b0;
            if (redir_bad) begin
                pc_next    = pc_reg;
                state_next = FAULT;
                fault_next = 1'b1;
            end else begin
                pc_next    = redirect_pc & ~32'd3;
                state_next = ((state_reg != IDLE) && halt) ? HALT : RUN;
                fault_next = fault_reg;
            end
        end
    end

    assign wr_idx     = count_reg - CW'(pop);
    assign count_next = flush ? '0 : (count_reg - CW'(pop) + CW'(push));

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_ent
            if (gi < FIFO_DEPTH - 1) begin : g_mid
                assign shift_src[gi] = ent_reg[gi+1];
            end else begin : g_last
                assign shift_src[gi] = ent_reg[gi];
            end
            // On flush the data is left stale; count alone marks entries invalid.
            assign ent_next[gi] = flush ? ent_reg[gi] :
                                  (push && (wr_idx == CW'(gi))) ? {pc_reg, rom_inst} :
                                  pop ? shift_src[gi] : ent_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            count_reg <= '0;
            fault_reg <= 1'b0;
            ent_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
            fault_reg <= fault_next;
            ent_reg   <= ent_next;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: small ROM model plus a scoreboard of expected {pc, inst} pairs.
// Builds with or without INST_FETCH_BOUNDS_CHECK_EN.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_ready;
    logic [31:0] rom_addr, rom_inst, out_inst, out_pc;
    logic        out_valid, fault;

    int          checks = 0;
    int          passed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_model(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h0000_0000;
            32'h04:  return 32'h3C01_1234;
            32'h08:  return 32'h3C02_5678;
            32'h0C:  return 32'h0022_1820;
            32'h30:  return 32'h1021_FFFB;
            default: return ~a;
        endcase
    endfunction

    assign rom_inst = rom_model(rom_addr);

    inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .fault(fault)
    );

    // Stimulus only: leaves the bench at the negedge where rst was released.
    task automatic do_reset(input logic rdy);
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0; out_ready = rdy;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) $display("FAIL reset_out: got %h/%h want 0/0", out_pc, out_inst); else passed++;
        checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else passed++;
        checks++; if (rom_addr !== 32'h0) $display("FAIL reset_pc: got %h want 00000000", rom_addr); else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || rom_addr !== 32'h0) $display("FAIL idle_nofetch: got v=%b addr=%h want 0/0", out_valid, rom_addr); else passed++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || rom_addr !== 32'h4)
            $display("FAIL first_inst: got v=%b pc=%h addr=%h want 1/0/4", out_valid, out_pc, rom_addr); else passed++;
        $display("reset: first instruction at pc=%h", out_pc);
    endtask

    task automatic test_stream;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back({32'(i * 4), rom_model(32'(i * 4))});
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (out_valid !== 1'b0) $display("FAIL stream_idle: got %b want 0", out_valid); else passed++;
            end else begin
                checks++; if (out_valid !== 1'b1) $display("FAIL stream_gap: cycle %0d got v=%b want 1", k, out_valid); else passed++;
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++; if ({out_pc, out_inst} !== e) $display("FAIL stream_data: got %h want %h", {out_pc, out_inst}, e); else passed++;
                    $display("stream: pc=%h inst=%h", out_pc, out_inst);
                end
            end
        end
        checks++; if (exp_q.size() != 0) $display("FAIL stream_left: got %0d entries want 0", exp_q.size()); else passed++;
    endtask

    task automatic test_backpressure;
        do_reset(1'b0);
        repeat (6) @(negedge clk);
        checks++; if (rom_addr !== 32'h8) $display("FAIL bp_pc_hold: got %h want 00000008", rom_addr); else passed++;
        for (int i = 0; i < 3; i++) exp_q.push_back({32'(i * 4), rom_model(32'(i * 4))});
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++; if (out_valid !== 1'b1) $display("FAIL bp_gap: beat %0d got v=%b want 1", k, out_valid); else passed++;
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++; if ({out_pc, out_inst} !== e) $display("FAIL bp_data: got %h want %h", {out_pc, out_inst}, e); else passed++;
                $display("backpressure: pc=%h inst=%h", out_pc, out_inst);
            end
        end
        checks++; if (exp_q.size() != 0) $display("FAIL bp_left: got %0d entries want 0", exp_q.size()); else passed++;
    endtask

    task automatic test_redirect;
        bit found = 0;
        do_reset(1'b1);
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (out_valid && out_pc == 32'h2C) found = 1;
        end
        checks++; if (!found) $display("FAIL redir_reach: got no pc 0000002c want it within 30 cycles"); else passed++;
        if (found) begin
            exp_q.push_back({32'h2C, rom_model(32'h2C)});
            exp_q.push_back({32'h30, 32'h1021_FFFB});
            exp_q.push_back({32'h34, rom_model(32'h34)});
            e = exp_q.pop_front();
            checks++; if ({out_pc, out_inst} !== e) $display("FAIL redir_pop: got %h want %h", {out_pc, out_inst}, e); else passed++;
            redirect = 1'b1; redirect_pc = 32'h30;
            @(negedge clk);
            redirect = 1'b0;
            checks++; if (out_valid !== 1'b0) $display("FAIL redir_flush: got v=%b want 0", out_valid); else passed++;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                checks++; if (out_valid !== 1'b1) $display("FAIL redir_latency: beat %0d got v=%b want 1", k, out_valid); else passed++;
                if (out_valid && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++; if ({out_pc, out_inst} !== e) $display("FAIL redir_data: got %h want %h", {out_pc, out_inst}, e); else passed++;
                    $display("redirect: pc=%h inst=%h", out_pc, out_inst);
                end
            end
        end
    endtask

    task automatic test_halt;
        bit found = 0;
        do_reset(1'b1);
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (rom_addr == 32'h10) found = 1;
        end
        checks++; if (!found) $display("FAIL halt_reach: got no rom_addr 00000010 want it within 30 cycles"); else passed++;
        if (found) begin
            exp_q.push_back({32'h0C, rom_model(32'h0C)});
            exp_q.push_back({32'h10, rom_model(32'h10)});
            e = exp_q.pop_front();
            checks++; if ({out_pc, out_inst} !== e) $display("FAIL halt_head: got %h want %h", {out_pc, out_inst}, e); else passed++;
            halt = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                checks++; if (out_valid !== 1'b0 || rom_addr !== 32'h10)
                    $display("FAIL halt_hold: got v=%b addr=%h want 0/00000010", out_valid, rom_addr); else passed++;
            end
            halt = 1'b0;
            found = 0;
            for (int k = 0; k < 5 && !found; k++) begin
                @(negedge clk);
                if (out_valid) found = 1;
            end
            checks++; if (!found) $display("FAIL halt_resume: got no valid want one within 5 cycles"); else passed++;
            if (found && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++; if ({out_pc, out_inst} !== e) $display("FAIL halt_data: got %h want %h", {out_pc, out_inst}, e); else passed++;
                $display("halt: resumed at pc=%h", out_pc);
            end
        end
    endtask

    task automatic test_fault;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        redirect = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) $display("FAIL fault_flush: got v=%b want 0", out_valid); else passed++;
`ifdef INST_FETCH_BOUNDS_CHECK_EN
        checks++; if (fault !== 1'b1) $display("FAIL fault_set: got %b want 1", fault); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (fault !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL fault_hold: got f=%b v=%b want 1/0", fault, out_valid); else passed++;
        $display("fault: fault=%b out_valid=%b", fault, out_valid);
`else
        checks++; if (fault !== 1'b0 || rom_addr !== 32'h80)
            $display("FAIL nofault_fetch: got f=%b addr=%h want 0/00000080", fault, rom_addr); else passed++;
        exp_q.push_back({32'h80, rom_model(32'h80)});
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || fault !== 1'b0) $display("FAIL nofault_valid: got v=%b f=%b want 1/0", out_valid, fault); else passed++;
        if (out_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++; if ({out_pc, out_inst} !== e) $display("FAIL nofault_data: got %h want %h", {out_pc, out_inst}, e); else passed++;
            $display("fault: disabled, pc=%h inst=%h", out_pc, out_inst);
        end
`endif
    endtask

`ifndef INST_FETCH_BOUNDS_CHECK_EN
    task automatic test_wrap;
        do_reset(1'b1);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL wrap_flush: got v=%b want 0", out_valid); else passed++;
        exp_q.push_back({32'hFFFF_FFFC, rom_model(32'hFFFF_FFFC)});
        exp_q.push_back({32'h0, rom_model(32'h0)});
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) $display("FAIL wrap_valid: beat %0d got v=%b want 1", k, out_valid); else passed++;
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++; if ({out_pc, out_inst} !== e) $display("FAIL wrap_data: got %h want %h", {out_pc, out_inst}, e); else passed++;
                $display("wrap: pc=%h inst=%h", out_pc, out_inst);
            end
        end
    endtask
`endif

    task automatic test_async_reset;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || rom_addr !== 32'h8)
            $display("FAIL ar_pre: got v=%b addr=%h want 1/00000008", out_valid, rom_addr); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || rom_addr !== 32'h0 || out_pc !== 32'h0 || out_inst !== 32'h0)
            $display("FAIL ar_clear: got v=%b addr=%h pc=%h inst=%h want 0/0/0/0", out_valid, rom_addr, out_pc, out_inst); else passed++;
        $display("async_reset: out_valid=%b rom_addr=%h", out_valid, rom_addr);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_fault();
`ifndef INST_FETCH_BOUNDS_CHECK_EN
        test_wrap();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
